// File: rtl/mem_lsu_if.sv
// Execute -> LSU op handoff, LSU -> data-memory request/response, and LSU -> writeback result.
// slave is the LSU's view; master is the surrounding pipeline and memory.
interface mem_lsu_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [2:0]  ex_funct3;
   logic        ex_is_load;
   logic        ex_is_store;
   logic [4:0]  ex_rd;

   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;

   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [31:0] exc_addr;

   modport slave (
      input  ex_valid, ex_addr, ex_wdata, ex_funct3, ex_is_load, ex_is_store, ex_rd,
      output ex_ready,
      output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rdata,
      output wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_addr
   );

   modport master (
      output ex_valid, ex_addr, ex_wdata, ex_funct3, ex_is_load, ex_is_store, ex_rd,
      input  ex_ready,
      input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rdata,
      input  wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_addr
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store stage: one registered wb result per op; non-mem/fault 1 cycle, store >=2, load >=3.
// Stalls execute (ex_ready low) while a bus access is outstanding; wb has no backpressure.
module mem_lsu #(
   parameter int XLEN = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   mem_lsu_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state_q, state_d;
   logic              dmem_req_valid_q, dmem_req_valid_d;
   logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
   logic              dmem_we_q, dmem_we_d;
   logic [3:0]        dmem_be_q, dmem_be_d;
   logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              exc_valid_q, exc_valid_d;
   logic [XLEN-1:0]   exc_addr_q, exc_addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;

   logic              is_mem, illegal, misaligned, fault;
   logic [3:0]        be_new;
   logic [XLEN-1:0]   wdata_new, rsp_shift, load_data;

   // Decode of the op currently offered by execute
   always_comb begin
      is_mem     = bus.ex_is_load | bus.ex_is_store;
      illegal    = (bus.ex_funct3 == 3'd3) || (bus.ex_funct3 == 3'd6) || (bus.ex_funct3 == 3'd7);
      misaligned = 1'b0;
      be_new     = 4'hF;
      wdata_new  = bus.ex_wdata;
      case (bus.ex_funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << bus.ex_addr[1:0];
            wdata_new = {4{bus.ex_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = bus.ex_addr[0];
            be_new     = 4'b0011 << {bus.ex_addr[1], 1'b0};
            wdata_new  = {2{bus.ex_wdata[15:0]}};
         end
         default: begin
            misaligned = |bus.ex_addr[1:0];
         end
      endcase
      fault = is_mem & (illegal | misaligned);
   end

   // Lane extraction of the returned word; sign-extend B/H, zero-extend BU/HU
   always_comb begin
      rsp_shift = bus.dmem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'd0:    load_data = {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]};
         3'd1:    load_data = {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
         3'd4:    load_data = {{(XLEN-8){1'b0}}, rsp_shift[7:0]};
         3'd5:    load_data = {{(XLEN-16){1'b0}}, rsp_shift[15:0]};
         default: load_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      dmem_req_valid_d = dmem_req_valid_q;
      dmem_addr_d      = dmem_addr_q;
      dmem_we_d        = dmem_we_q;
      dmem_be_d        = dmem_be_q;
      dmem_wdata_d     = dmem_wdata_q;
      wb_valid_d       = 1'b0;
      wb_we_d          = wb_we_q;
      wb_rd_d          = wb_rd_q;
      wb_data_d        = wb_data_q;
      exc_valid_d      = 1'b0;
      exc_addr_d       = exc_addr_q;
      funct3_d         = funct3_q;
      off_d            = off_q;
      rd_d             = rd_q;

      case (state_q)
         IDLE: begin
            if (bus.ex_valid) begin
               funct3_d = bus.ex_funct3;
               off_d    = bus.ex_addr[1:0];
               rd_d     = bus.ex_rd;
               wb_rd_d  = bus.ex_rd;
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = (bus.ex_rd != 5'd0);
                  wb_data_d  = bus.ex_addr;
               end else if (fault) begin
                  wb_valid_d  = 1'b1;
                  wb_we_d     = 1'b0;
                  exc_valid_d = 1'b1;
                  exc_addr_d  = bus.ex_addr;
               end else begin
                  state_d          = REQ;
                  dmem_req_valid_d = 1'b1;
                  dmem_addr_d      = {bus.ex_addr[XLEN-1:2], 2'b00};
                  dmem_we_d        = bus.ex_is_store;
                  dmem_be_d        = be_new;
                  dmem_wdata_d     = wdata_new;
               end
            end
         end
         REQ: begin
            if (bus.dmem_req_ready) begin
               dmem_req_valid_d = 1'b0;
               if (dmem_we_q) begin
                  // Stores are posted: retire as soon as the bus takes them
                  state_d    = IDLE;
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_rd_d    = rd_q;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.dmem_rsp_valid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_we_d    = (rd_q != 5'd0);
               wb_rd_d    = rd_q;
               wb_data_d  = load_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         dmem_req_valid_q <= 1'b0;
         dmem_addr_q      <= '0;
         dmem_we_q        <= 1'b0;
         dmem_be_q        <= 4'h0;
         dmem_wdata_q     <= '0;
         wb_valid_q       <= 1'b0;
         wb_we_q          <= 1'b0;
         wb_rd_q          <= 5'd0;
         wb_data_q        <= '0;
         exc_valid_q      <= 1'b0;
         exc_addr_q       <= '0;
         funct3_q         <= 3'd0;
         off_q            <= 2'd0;
         rd_q             <= 5'd0;
      end else begin
         state_q          <= state_d;
         dmem_req_valid_q <= dmem_req_valid_d;
         dmem_addr_q      <= dmem_addr_d;
         dmem_we_q        <= dmem_we_d;
         dmem_be_q        <= dmem_be_d;
         dmem_wdata_q     <= dmem_wdata_d;
         wb_valid_q       <= wb_valid_d;
         wb_we_q          <= wb_we_d;
         wb_rd_q          <= wb_rd_d;
         wb_data_q        <= wb_data_d;
         exc_valid_q      <= exc_valid_d;
         exc_addr_q       <= exc_addr_d;
         funct3_q         <= funct3_d;
         off_q            <= off_d;
         rd_q             <= rd_d;
      end
   end

   assign bus.ex_ready       = (state_q == IDLE);
   assign bus.dmem_req_valid = dmem_req_valid_q;
   assign bus.dmem_addr      = dmem_addr_q;
   assign bus.dmem_we        = dmem_we_q;
   assign bus.dmem_be        = dmem_be_q;
   assign bus.dmem_wdata     = dmem_wdata_q;
   assign bus.wb_valid       = wb_valid_q;
   assign bus.wb_we          = wb_we_q;
   assign bus.wb_rd          = wb_rd_q;
   assign bus.wb_data        = wb_data_q;
   assign bus.exc_valid      = exc_valid_q;
   assign bus.exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus random ops, each checked against a byte-level reference model.
module tb_mem_lsu;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   mem_lsu_if bus_if();

   mem_lsu #(.XLEN(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: access size in bytes, faults, lanes and load value from byte arithmetic
   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic model_fault(input logic [2:0] f3, input logic [31:0] addr);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      return (addr % nbytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be;
      int off;
      be  = 4'h0;
      off = int'(addr % 4);
      for (int i = 0; i < nbytes(f3); i++) be[off + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] v;
      int n;
      n = nbytes(f3);
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      int n, off;
      v   = 32'h0;
      n   = nbytes(f3);
      off = int'(addr % 4);
      for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
      if (f3 < 3'd4 && n < 4 && v[8*n - 1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic idle_inputs();
      bus_if.ex_valid       = 1'b0;
      bus_if.ex_addr        = $urandom;
      bus_if.ex_wdata       = $urandom;
      bus_if.ex_funct3      = 3'(($urandom_range(0, 7)));
      bus_if.ex_is_load     = 1'b0;
      bus_if.ex_is_store    = 1'b0;
      bus_if.ex_rd          = 5'(($urandom_range(0, 31)));
      bus_if.dmem_req_ready = 1'b0;
      bus_if.dmem_rsp_valid = 1'b0;
      bus_if.dmem_rdata     = $urandom;
   endtask

   // Called just after a negedge; drives one op through accept, bus phases and writeback
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      check("ex_ready_pre", bus_if.ex_ready, 1'b1);
      bus_if.ex_valid    = 1'b1;
      bus_if.ex_is_load  = ld;
      bus_if.ex_is_store = st;
      bus_if.ex_funct3   = f3;
      bus_if.ex_addr     = addr;
      bus_if.ex_wdata    = wd;
      bus_if.ex_rd       = rd;
      @(negedge clk);
      idle_inputs();

      if (!(ld || st)) begin
         check("alu_wb_valid", bus_if.wb_valid, 1'b1);
         check("alu_wb_we", bus_if.wb_we, rd != 5'd0);
         check("alu_wb_rd", bus_if.wb_rd, rd);
         check("alu_wb_data", bus_if.wb_data, addr);
         check("alu_exc", bus_if.exc_valid, 1'b0);
         check("alu_req", bus_if.dmem_req_valid, 1'b0);
         @(negedge clk);
         check("alu_wb_pulse", bus_if.wb_valid, 1'b0);
         return;
      end

      if (model_fault(f3, addr)) begin
         check("exc_wb_valid", bus_if.wb_valid, 1'b1);
         check("exc_valid", bus_if.exc_valid, 1'b1);
         check("exc_addr", bus_if.exc_addr, addr);
         check("exc_wb_we", bus_if.wb_we, 1'b0);
         check("exc_no_req", bus_if.dmem_req_valid, 1'b0);
         @(negedge clk);
         check("exc_pulse", bus_if.exc_valid, 1'b0);
         check("exc_wb_pulse", bus_if.wb_valid, 1'b0);
         check("exc_no_req2", bus_if.dmem_req_valid, 1'b0);
         return;
      end

      for (int i = 0; i <= rdy_dly; i++) begin
         check("req_valid", bus_if.dmem_req_valid, 1'b1);
         check("req_addr", bus_if.dmem_addr, addr & 32'hFFFF_FFFC);
         check("req_we", bus_if.dmem_we, st);
         if (st) begin
            check("req_be", bus_if.dmem_be, model_be(f3, addr));
            check("req_wdata", bus_if.dmem_wdata, model_wdata(f3, wd));
         end
         check("req_ex_ready", bus_if.ex_ready, 1'b0);
         check("req_wb_idle", bus_if.wb_valid, 1'b0);
         if (i == rdy_dly) bus_if.dmem_req_ready = 1'b1;
         else bus_if.dmem_rsp_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         bus_if.dmem_req_ready = 1'b0;
         bus_if.dmem_rsp_valid = 1'b0;
      end

      if (st) begin
         check("st_wb_valid", bus_if.wb_valid, 1'b1);
         check("st_wb_we", bus_if.wb_we, 1'b0);
         check("st_exc", bus_if.exc_valid, 1'b0);
         check("st_req_drop", bus_if.dmem_req_valid, 1'b0);
         @(negedge clk);
         check("st_wb_pulse", bus_if.wb_valid, 1'b0);
         return;
      end

      for (int i = 0; i < rsp_dly; i++) begin
         check("ld_req_drop", bus_if.dmem_req_valid, 1'b0);
         check("ld_wait_wb", bus_if.wb_valid, 1'b0);
         @(negedge clk);
      end
      bus_if.dmem_rsp_valid = 1'b1;
      bus_if.dmem_rdata     = rdata;
      @(negedge clk);
      bus_if.dmem_rsp_valid = 1'b0;
      bus_if.dmem_rdata     = $urandom;
      check("ld_wb_valid", bus_if.wb_valid, 1'b1);
      check("ld_wb_we", bus_if.wb_we, rd != 5'd0);
      check("ld_wb_rd", bus_if.wb_rd, rd);
      check("ld_wb_data", bus_if.wb_data, model_load(f3, addr, rdata));
      check("ld_exc", bus_if.exc_valid, 1'b0);
      @(negedge clk);
      check("ld_wb_pulse", bus_if.wb_valid, 1'b0);
   endtask

   initial begin
      logic [2:0] st_f3 [6];
      n_vec = 0;
      n_err = 0;
      st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      rst_n = 1'b0;
      idle_inputs();

      repeat (2) @(negedge clk);
      check("rst_ex_ready", bus_if.ex_ready, 1'b1);
      check("rst_req_valid", bus_if.dmem_req_valid, 1'b0);
      check("rst_we", bus_if.dmem_we, 1'b0);
      check("rst_addr", bus_if.dmem_addr, 32'h0);
      check("rst_be", bus_if.dmem_be, 4'h0);
      check("rst_wdata", bus_if.dmem_wdata, 32'h0);
      check("rst_wb_valid", bus_if.wb_valid, 1'b0);
      check("rst_wb_we", bus_if.wb_we, 1'b0);
      check("rst_wb_rd", bus_if.wb_rd, 5'd0);
      check("rst_wb_data", bus_if.wb_data, 32'h0);
      check("rst_exc_valid", bus_if.exc_valid, 1'b0);
      check("rst_exc_addr", bus_if.exc_addr, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three back-to-back non-memory ops retire one per cycle
      bus_if.ex_valid    = 1'b1;
      bus_if.ex_is_load  = 1'b0;
      bus_if.ex_is_store = 1'b0;
      bus_if.ex_addr     = 32'h1234;
      bus_if.ex_rd       = 5'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("b2b_ex_ready", bus_if.ex_ready, 1'b1);
         check("b2b_wb_valid", bus_if.wb_valid, 1'b1);
         check("b2b_wb_data", bus_if.wb_data, 32'h1234);
         check("b2b_wb_we", bus_if.wb_we, 1'b1);
         check("b2b_wb_rd", bus_if.wb_rd, 5'd5);
      end
      idle_inputs();
      @(negedge clk);
      check("b2b_end", bus_if.wb_valid, 1'b0);

      run_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 5'd3, 3, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'd0, 32'h2001, 32'h0, 5'd9, 0, 0, 32'h0000_8000);
      run_op(1'b1, 1'b0, 3'd4, 32'h2001, 32'h0, 5'd9, 0, 0, 32'h0000_8000);
      run_op(1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 5'd10, 1, 2, 32'hBEEF_0000);
      run_op(1'b1, 1'b0, 3'd2, 32'h3002, 32'h0, 5'd11, 0, 0, 32'h0);
      run_op(1'b0, 1'b1, 3'd1, 32'h1006, 32'h0000_C0DE, 5'd0, 0, 0, 32'h0);
      run_op(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);

      // Async reset while a load waits for its response
      bus_if.ex_valid   = 1'b1;
      bus_if.ex_is_load = 1'b1;
      bus_if.ex_funct3  = 3'd2;
      bus_if.ex_addr    = 32'h5000;
      bus_if.ex_rd      = 5'd7;
      @(negedge clk);
      idle_inputs();
      bus_if.dmem_req_ready = 1'b1;
      @(negedge clk);
      bus_if.dmem_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rstw_req_valid", bus_if.dmem_req_valid, 1'b0);
      check("rstw_ex_ready", bus_if.ex_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.dmem_rsp_valid = 1'b1;
      bus_if.dmem_rdata     = 32'h1111_2222;
      @(negedge clk);
      bus_if.dmem_rsp_valid = 1'b0;
      check("rstw_no_wb", bus_if.wb_valid, 1'b0);
      check("rstw_ready", bus_if.ex_ready, 1'b1);
      @(negedge clk);
      check("rstw_no_wb2", bus_if.wb_valid, 1'b0);

      // Async reset while a request is pending drops dmem_req_valid at once
      bus_if.ex_valid   = 1'b1;
      bus_if.ex_is_load = 1'b1;
      bus_if.ex_funct3  = 3'd2;
      bus_if.ex_addr    = 32'h5004;
      @(negedge clk);
      idle_inputs();
      check("rstr_req_before", bus_if.dmem_req_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstr_req_drop", bus_if.dmem_req_valid, 1'b0);
      check("rstr_ex_ready", bus_if.ex_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstr_no_req", bus_if.dmem_req_valid, 1'b0);
      check("rstr_no_wb", bus_if.wb_valid, 1'b0);

      for (int n = 0; n < 300; n++) begin
         int          kind;
         logic [2:0]  f3;
         logic [31:0] addr;
         kind = int'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         if (kind == 2) f3 = st_f3[$urandom_range(0, 5)];
         else f3 = 3'(($urandom_range(0, 7)));
         run_op(kind == 1, kind == 2, f3, addr, $urandom, 5'(($urandom_range(0, 31))),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
